// File: rtl/id_issue_pkg.sv
// -----------------------------------------------------------------------------
// id_issue_pkg
// Shared definitions for the decode/issue slice:
//   - RV32I major opcode constants
//   - ALU-select class encoding (ex_alusel[4:3]) and fixed special codes
//   - instruction-queue entry struct and decoded-instruction struct
//   - decode() helper that maps an instruction word to its decoded fields
// -----------------------------------------------------------------------------
package id_issue_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;

  // ex_alusel[4:3]; CLS_SPECIAL holds the ops whose low bits are not funct3.
  typedef enum logic [1:0] {
    CLS_ALU     = 2'b00,
    CLS_SPECIAL = 2'b01,
    CLS_BRANCH  = 2'b10,
    CLS_LOAD    = 2'b11
  } alu_class_e;

  localparam logic [4:0] ALU_LUI   = {CLS_SPECIAL, 3'd0};
  localparam logic [4:0] ALU_AUIPC = {CLS_SPECIAL, 3'd1};
  localparam logic [4:0] ALU_JAL   = {CLS_SPECIAL, 3'd2};
  localparam logic [4:0] ALU_JALR  = {CLS_SPECIAL, 3'd3};
  localparam logic [4:0] ALU_SB    = {CLS_SPECIAL, 3'd4};
  localparam logic [4:0] ALU_SH    = {CLS_SPECIAL, 3'd5};
  localparam logic [4:0] ALU_SW    = {CLS_SPECIAL, 3'd6};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
  } iq_entry_t;

  typedef struct packed {
    logic [4:0]  alusel;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        wreg;
    logic        load;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t        d;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3    = inst[14:12];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    d = '0;
    case (inst[6:0])
      OPC_OP_IMM: begin d.alusel = {CLS_ALU, f3}; d.imm = imm_i; d.use_rs1 = 1'b1; d.wreg = 1'b1; end
      OPC_OP:     begin d.alusel = {CLS_ALU, f3}; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.wreg = 1'b1; end
      OPC_LUI:    begin d.alusel = ALU_LUI;   d.imm = imm_u; d.wreg = 1'b1; end
      OPC_AUIPC:  begin d.alusel = ALU_AUIPC; d.imm = imm_u; d.wreg = 1'b1; end
      OPC_JAL:    begin d.alusel = ALU_JAL;   d.imm = imm_j; d.wreg = 1'b1; end
      OPC_JALR:   begin d.alusel = ALU_JALR;  d.imm = imm_i; d.use_rs1 = 1'b1; d.wreg = 1'b1; end
      OPC_BRANCH: begin d.alusel = {CLS_BRANCH, f3}; d.imm = imm_b; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      OPC_LOAD:   begin
        d.alusel = {CLS_LOAD, f3}; d.imm = imm_i; d.use_rs1 = 1'b1; d.wreg = 1'b1; d.load = 1'b1;
      end
      OPC_STORE:  begin
        d.alusel  = (f3 == 3'd0) ? ALU_SB : (f3 == 3'd1) ? ALU_SH : ALU_SW;
        d.imm     = imm_s;
        d.use_rs1 = 1'b1;
        d.use_rs2 = 1'b1;
      end
      default: ; // unknown opcode: no write, alusel 0, no source reads
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_inst_queue.sv
// -----------------------------------------------------------------------------
// id_inst_queue
// Circular instruction queue between fetch and decode.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the queue next cycle; a push in the same cycle is dropped
//   push, push_data write one entry when not full (no bypass when full)
//   pop             remove head entry when not empty
//   head            current head entry (valid only when !empty)
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module id_inst_queue
  import id_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  output iq_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  iq_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the occupancy counter alone decides
  // which entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/id_issue.sv
// -----------------------------------------------------------------------------
// id_issue
// Decode/issue stage: queues fetched instructions, decodes the head, resolves
// operands (x0, forwarding, register file), detects hazards against the held
// output register, a load in EX and an outstanding-load scoreboard, and issues
// into a registered valid/ready payload toward EX.
// Parameters: IQ_DEPTH (queue entries, power of two), LOAD_LAT (load latency).
// Ports:
//   clk, rst, flush                  clock, sync active-high reset, redirect
//   if_valid/if_pc/if_inst/if_br     fetch push, if_ready = queue not full
//   rf_raddr1/2, rf_rdata1/2         combinational register-file read
//   fwd_ex_*, fwd_mem_*, mem_stall   forwarding sources, MEM stall
//   ex_valid/ex_ready, ex_*          registered issue payload to EX
// Optional: define ID_ISSUE_DBG_INST_EN to add ex_inst (issued instruction word).
// -----------------------------------------------------------------------------
module id_issue
  import id_issue_pkg::*;
#(
  parameter int IQ_DEPTH = 4,
  parameter int LOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        if_br,
  output logic        if_ready,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        fwd_ex_we,
  input  logic [4:0]  fwd_ex_wd,
  input  logic [31:0] fwd_ex_data,
  input  logic        fwd_ex_load,
  input  logic        fwd_mem_we,
  input  logic [4:0]  fwd_mem_wd,
  input  logic [31:0] fwd_mem_data,
  input  logic        mem_stall,
`ifdef ID_ISSUE_DBG_INST_EN
  output logic [31:0] ex_inst,
`endif
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [4:0]  ex_alusel,
  output logic [31:0] ex_opr1,
  output logic [31:0] ex_opr2,
  output logic [31:0] ex_opr3,
  output logic [31:0] ex_opr4,
  output logic [4:0]  ex_wd,
  output logic        ex_wreg,
  output logic        ex_br,
  output logic        ex_load
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  iq_entry_t   head;
  logic        q_full, q_empty;
  dec_t        dec;
  logic [4:0]  rd;
  logic        hazard, issue;

  logic [4:0]  src_addr [2];
  logic [31:0] src_rf   [2];
  logic [31:0] src_val  [2];
  logic        src_haz  [2];
  logic        sb_hit   [2];

  logic          sb_valid [LOAD_LAT];
  logic [4:0]    sb_rd    [LOAD_LAT];
  logic [CW-1:0] sb_cnt   [LOAD_LAT];
  logic          sb_free_now [LOAD_LAT];
  logic          sb_alloc, sb_full;
  int            sb_alloc_idx;

  assign if_ready = !q_full;

  id_inst_queue #(.DEPTH(IQ_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (if_valid && if_ready),
    .push_data ('{pc: if_pc, inst: if_inst, br: if_br}),
    .pop       (issue),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign dec       = decode(head.inst);
  assign rd        = head.inst[11:7];
  assign rf_raddr1 = head.inst[19:15];
  assign rf_raddr2 = head.inst[24:20];
  assign src_addr[0] = rf_raddr1;
  assign src_addr[1] = rf_raddr2;
  assign src_rf[0]   = rf_rdata1;
  assign src_rf[1]   = rf_rdata2;

  // A load hands off into EX this cycle and will occupy a scoreboard slot.
  assign sb_alloc = ex_valid && ex_ready && ex_load && (ex_wd != 5'd0);

  // Scoreboard lookups, slot selection and occupancy after this edge.
  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    int kept;
    logic found;
    kept         = 0;
    found        = 1'b0;
    sb_alloc_idx = 0;
    sb_hit[0]    = 1'b0;
    sb_hit[1]    = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      sb_free_now[j] = sb_valid[j] && !mem_stall && (sb_cnt[j] == CW'(1));
      if (sb_valid[j] && sb_rd[j] == src_addr[0]) sb_hit[0] = 1'b1;
      if (sb_valid[j] && sb_rd[j] == src_addr[1]) sb_hit[1] = 1'b1;
      if (sb_valid[j] && !sb_free_now[j]) kept++;
      // A slot freeing this cycle may be reallocated in the same cycle.
      if (!found && (!sb_valid[j] || sb_free_now[j])) begin
        found        = 1'b1;
        sb_alloc_idx = j;
      end
    end
    sb_full = (kept + (sb_alloc ? 1 : 0)) >= LOAD_LAT;
  end

  // Per-operand source selection, highest priority first.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      src_val[k] = src_rf[k];
      src_haz[k] = 1'b0;
      if (src_addr[k] == 5'd0) begin
        src_val[k] = '0;
      end else if (ex_valid && ex_wreg && ex_wd == src_addr[k]) begin
        // Producer still sits in the output register; its result is not
        // available anywhere yet.
        src_haz[k] = 1'b1;
      end else if (fwd_ex_we && fwd_ex_wd == src_addr[k]) begin
        if (fwd_ex_load) src_haz[k] = 1'b1;
        else             src_val[k] = fwd_ex_data;
      end else if (fwd_mem_we && fwd_mem_wd == src_addr[k]) begin
        src_val[k] = fwd_mem_data;
      end else if (sb_hit[k]) begin
        src_haz[k] = 1'b1;
      end
    end
  end

  assign hazard = (dec.use_rs1 && src_haz[0]) || (dec.use_rs2 && src_haz[1]) ||
                  (dec.load && rd != 5'd0 && sb_full);
  assign issue  = !q_empty && !hazard && (!ex_valid || ex_ready) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_alusel <= '0;
      ex_opr1   <= '0;
      ex_opr2   <= '0;
      ex_opr3   <= '0;
      ex_opr4   <= '0;
      ex_wd     <= '0;
      ex_wreg   <= 1'b0;
      ex_br     <= 1'b0;
      ex_load   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (issue) begin
      ex_valid  <= 1'b1;
      ex_alusel <= dec.alusel;
      ex_opr1   <= dec.use_rs1 ? src_val[0] : dec.imm;
      ex_opr2   <= dec.use_rs2 ? src_val[1] : dec.imm;
      ex_opr3   <= (dec.use_rs1 && dec.use_rs2) ? dec.imm : '0;
      ex_opr4   <= head.pc;
      ex_wd     <= dec.wreg ? rd : 5'd0;
      ex_wreg   <= dec.wreg;
      ex_br     <= head.br;
      ex_load   <= dec.load;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Scoreboard survives flush: loads already handed off still return data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LOAD_LAT; j++) begin
        sb_valid[j] <= 1'b0;
        sb_rd[j]    <= '0;
        sb_cnt[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < LOAD_LAT; j++) begin
        if (sb_valid[j] && !mem_stall) begin
          sb_cnt[j] <= sb_cnt[j] - 1'b1;
          if (sb_cnt[j] == CW'(1)) sb_valid[j] <= 1'b0;
        end
        if (sb_alloc && j == sb_alloc_idx) begin
          sb_valid[j] <= 1'b1;
          sb_rd[j]    <= ex_wd;
          sb_cnt[j]   <= CW'(LOAD_LAT);
        end
      end
    end
  end

`ifdef ID_ISSUE_DBG_INST_EN
  always_ff @(posedge clk) begin
    if (rst || flush) ex_inst <= '0;
    else if (issue)   ex_inst <= head.inst;
  end
`endif

endmodule

// File: tb/tb_id_issue.sv
// -----------------------------------------------------------------------------
// tb_id_issue
// Directed self-checking bench for id_issue (IQ_DEPTH=4, LOAD_LAT=2).
// Inputs are driven and outputs sampled at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_id_issue;

  logic        clk, rst, flush;
  logic        if_valid, if_br, if_ready;
  logic [31:0] if_pc, if_inst;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        fwd_ex_we, fwd_ex_load, fwd_mem_we, mem_stall;
  logic [4:0]  fwd_ex_wd, fwd_mem_wd;
  logic [31:0] fwd_ex_data, fwd_mem_data;
  logic        ex_valid, ex_ready, ex_wreg, ex_br, ex_load;
  logic [4:0]  ex_alusel, ex_wd;
  logic [31:0] ex_opr1, ex_opr2, ex_opr3, ex_opr4;
`ifdef ID_ISSUE_DBG_INST_EN
  logic [31:0] ex_inst;
`endif

  logic [31:0] rf_mem [32];
  int n_pass = 0;
  int n_total = 0;

  // Hand-encoded instructions
  localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD_X2_X1   = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] I_LW_X3       = 32'h0000_2183; // lw   x3,0(x0)
  localparam logic [31:0] I_ADDI_X4_X3  = 32'h0011_8213; // addi x4,x3,1
  localparam logic [31:0] I_LUI_X7      = 32'h1234_53B7; // lui  x7,0x12345
  localparam logic [31:0] I_ADDI_X6_M1  = 32'hFFF0_0313; // addi x6,x0,-1
  localparam logic [31:0] I_BEQ_16      = 32'h0020_8863; // beq  x1,x2,+16
  localparam logic [31:0] I_SW_X2_8     = 32'h0020_A423; // sw   x2,8(x1)
  localparam logic [31:0] I_ILLEGAL     = 32'h0000_007F;
  localparam logic [31:0] I_ADD_X5_X0   = 32'h0000_02B3; // add  x5,x0,x0

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  id_issue #(.IQ_DEPTH(4), .LOAD_LAT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_br(if_br), .if_ready(if_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_wd(fwd_ex_wd), .fwd_ex_data(fwd_ex_data), .fwd_ex_load(fwd_ex_load),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_wd(fwd_mem_wd), .fwd_mem_data(fwd_mem_data), .mem_stall(mem_stall),
`ifdef ID_ISSUE_DBG_INST_EN
    .ex_inst(ex_inst),
`endif
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alusel(ex_alusel),
    .ex_opr1(ex_opr1), .ex_opr2(ex_opr2), .ex_opr3(ex_opr3), .ex_opr4(ex_opr4),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_br(ex_br), .ex_load(ex_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] addi_x8(input int k);
    return (32'(k) << 20) | 32'h0000_0413; // addi x8,x0,k
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; if_br = 1'b0;
    fwd_ex_we = 1'b0; fwd_ex_wd = '0; fwd_ex_data = '0; fwd_ex_load = 1'b0;
    fwd_mem_we = 1'b0; fwd_mem_wd = '0; fwd_mem_data = '0; mem_stall = 1'b0;
    ex_ready = 1'b1;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Push one instruction, then wait one more cycle so it issues.
  task automatic issue_one(input logic [31:0] pc, input logic [31:0] inst, input logic br);
    if_valid = 1'b1; if_pc = pc; if_inst = inst; if_br = br;
    tick();
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    n_total++; if (if_ready !== 1'b1) $display("FAIL rst_if_ready: got %b want 1", if_ready); else n_pass++;
    n_total++; if (ex_valid !== 1'b0) $display("FAIL rst_ex_valid: got %b want 0", ex_valid); else n_pass++;
    n_total++; if (ex_alusel !== 5'd0) $display("FAIL rst_alusel: got %h want 0", ex_alusel); else n_pass++;
    n_total++; if ({ex_opr1, ex_opr2, ex_opr3, ex_opr4} !== 128'd0)
      $display("FAIL rst_oprs: got %h %h %h %h want 0", ex_opr1, ex_opr2, ex_opr3, ex_opr4); else n_pass++;
    n_total++; if ({ex_wd, ex_wreg, ex_br, ex_load} !== 8'd0)
      $display("FAIL rst_flags: got wd=%0d wreg=%b br=%b load=%b want 0", ex_wd, ex_wreg, ex_br, ex_load); else n_pass++;
  endtask

  task automatic test_fwd_ex;
    do_reset();
    if_valid = 1'b1; if_inst = I_ADDI_X1_5; if_pc = 32'h10;
    tick();
    if_inst = I_ADD_X2_X1; if_pc = 32'h14;
    tick();
    if_valid = 1'b0;
    n_total++; if (ex_valid !== 1'b1 || ex_wd !== 5'd1 || ex_opr2 !== 32'd5 || ex_opr1 !== 32'd0)
      $display("FAIL fwd_addi_issue: got v=%b wd=%0d o1=%h o2=%h want 1 1 0 5", ex_valid, ex_wd, ex_opr1, ex_opr2); else n_pass++;
    tick();
    n_total++; if (ex_valid !== 1'b0) $display("FAIL fwd_bubble: got ex_valid=%b want 0", ex_valid); else n_pass++;
    fwd_ex_we = 1'b1; fwd_ex_wd = 5'd1; fwd_ex_data = 32'd5;
    tick();
    fwd_ex_we = 1'b0;
    n_total++; if (ex_valid !== 1'b1 || ex_wd !== 5'd2 || ex_alusel !== 5'h00)
      $display("FAIL fwd_add_issue: got v=%b wd=%0d sel=%h want 1 2 00", ex_valid, ex_wd, ex_alusel); else n_pass++;
    n_total++; if (ex_opr1 !== 32'd5 || ex_opr2 !== 32'd5 || ex_opr3 !== 32'd0)
      $display("FAIL fwd_add_oprs: got %h %h %h want 5 5 0", ex_opr1, ex_opr2, ex_opr3); else n_pass++;
    n_total++; if (ex_opr4 !== 32'h14) $display("FAIL fwd_add_pc: got %h want 14", ex_opr4); else n_pass++;
  endtask

  task automatic test_load_use;
    do_reset();
    if_valid = 1'b1; if_inst = I_LW_X3;
    tick();
    if_inst = I_ADDI_X4_X3;
    tick();
    if_valid = 1'b0;
    n_total++; if (ex_valid !== 1'b1 || ex_load !== 1'b1 || ex_alusel !== 5'h1A || ex_wd !== 5'd3)
      $display("FAIL lw_issue: got v=%b load=%b sel=%h wd=%0d want 1 1 1a 3", ex_valid, ex_load, ex_alusel, ex_wd); else n_pass++;
    tick(); // lw handed off, addi blocked by held producer
    n_total++; if (ex_valid !== 1'b0) $display("FAIL lu_hold_held: got ex_valid=%b want 0", ex_valid); else n_pass++;
    fwd_ex_we = 1'b1; fwd_ex_wd = 5'd3; fwd_ex_load = 1'b1; fwd_ex_data = 32'hDEAD;
    tick();
    fwd_ex_we = 1'b0; fwd_ex_load = 1'b0;
    n_total++; if (ex_valid !== 1'b0) $display("FAIL lu_hold_ex_load: got ex_valid=%b want 0", ex_valid); else n_pass++;
    tick(); // scoreboard entry still counting down
    n_total++; if (ex_valid !== 1'b0) $display("FAIL lu_hold_sb: got ex_valid=%b want 0", ex_valid); else n_pass++;
    fwd_mem_we = 1'b1; fwd_mem_wd = 5'd3; fwd_mem_data = 32'h1234;
    tick();
    fwd_mem_we = 1'b0;
    n_total++; if (ex_valid !== 1'b1 || ex_wd !== 5'd4) $display("FAIL lu_issue: got v=%b wd=%0d want 1 4", ex_valid, ex_wd); else n_pass++;
    n_total++; if (ex_opr1 !== 32'h1234 || ex_opr2 !== 32'd1)
      $display("FAIL lu_oprs: got %h %h want 1234 1", ex_opr1, ex_opr2); else n_pass++;
  endtask

  task automatic test_decode;
    do_reset();
    issue_one(32'h100, I_LUI_X7, 1'b0);
    n_total++; if (ex_alusel !== 5'h08 || ex_opr1 !== 32'h1234_5000 || ex_opr2 !== 32'h1234_5000 || ex_wd !== 5'd7)
      $display("FAIL dec_lui: got sel=%h o1=%h o2=%h wd=%0d want 08 12345000 12345000 7", ex_alusel, ex_opr1, ex_opr2, ex_wd); else n_pass++;
    n_total++; if (ex_opr4 !== 32'h100) $display("FAIL dec_lui_pc: got %h want 100", ex_opr4); else n_pass++;
    issue_one(32'h104, I_ADDI_X6_M1, 1'b0);
    n_total++; if (ex_opr1 !== 32'd0 || ex_opr2 !== 32'hFFFF_FFFF)
      $display("FAIL dec_addi_neg: got %h %h want 0 ffffffff", ex_opr1, ex_opr2); else n_pass++;
    issue_one(32'h108, I_BEQ_16, 1'b1);
    n_total++; if (ex_alusel !== 5'h10 || ex_wreg !== 1'b0 || ex_br !== 1'b1)
      $display("FAIL dec_beq_ctl: got sel=%h wreg=%b br=%b want 10 0 1", ex_alusel, ex_wreg, ex_br); else n_pass++;
    n_total++; if (ex_opr1 !== 32'h1001 || ex_opr2 !== 32'h1002 || ex_opr3 !== 32'd16)
      $display("FAIL dec_beq_oprs: got %h %h %h want 1001 1002 10", ex_opr1, ex_opr2, ex_opr3); else n_pass++;
    issue_one(32'h10C, I_SW_X2_8, 1'b0);
    n_total++; if (ex_alusel !== 5'h0E || ex_opr3 !== 32'd8 || ex_wreg !== 1'b0 || ex_br !== 1'b0)
      $display("FAIL dec_sw: got sel=%h o3=%h wreg=%b br=%b want 0e 8 0 0", ex_alusel, ex_opr3, ex_wreg, ex_br); else n_pass++;
    issue_one(32'h110, I_ILLEGAL, 1'b0);
    n_total++; if (ex_valid !== 1'b1 || ex_wreg !== 1'b0 || ex_alusel !== 5'd0)
      $display("FAIL dec_illegal: got v=%b wreg=%b sel=%h want 1 0 00", ex_valid, ex_wreg, ex_alusel); else n_pass++;
    fwd_ex_we = 1'b1; fwd_ex_wd = 5'd0; fwd_ex_data = 32'hDEAD_0000;
    fwd_mem_we = 1'b1; fwd_mem_wd = 5'd0; fwd_mem_data = 32'hBEEF_0000;
    issue_one(32'h114, I_ADD_X5_X0, 1'b0);
    fwd_ex_we = 1'b0; fwd_mem_we = 1'b0;
    n_total++; if (ex_opr1 !== 32'd0 || ex_opr2 !== 32'd0 || ex_wd !== 5'd5)
      $display("FAIL dec_x0: got %h %h wd=%0d want 0 0 5", ex_opr1, ex_opr2, ex_wd); else n_pass++;
  endtask

  task automatic test_full;
    do_reset();
    ex_ready = 1'b0;
    if_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if_inst = addi_x8(k);
      tick();
    end
    n_total++; if (ex_valid !== 1'b1 || ex_opr2 !== 32'd1 || if_ready !== 1'b1)
      $display("FAIL full_three_queued: got v=%b o2=%h rdy=%b want 1 1 1", ex_valid, ex_opr2, if_ready); else n_pass++;
    if_inst = addi_x8(5);
    tick();
    n_total++; if (if_ready !== 1'b0) $display("FAIL full_if_ready: got %b want 0", if_ready); else n_pass++;
    if_inst = addi_x8(6);
    tick();
    if_valid = 1'b0;
    n_total++; if (if_ready !== 1'b0 || ex_opr2 !== 32'd1)
      $display("FAIL full_stable: got rdy=%b o2=%h want 0 1", if_ready, ex_opr2); else n_pass++;
    ex_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick();
      n_total++; if (ex_valid !== 1'b1 || ex_opr2 !== 32'(k))
        $display("FAIL full_drain: got v=%b o2=%h want 1 %h", ex_valid, ex_opr2, k); else n_pass++;
    end
    tick();
    n_total++; if (ex_valid !== 1'b0) $display("FAIL full_refused: got ex_valid=%b want 0", ex_valid); else n_pass++;
  endtask

  task automatic test_flush;
    do_reset();
    ex_ready = 1'b0;
    if_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if_inst = addi_x8(k);
      tick();
    end
    flush = 1'b1;
    if_inst = addi_x8(5);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    n_total++; if (ex_valid !== 1'b0 || if_ready !== 1'b1)
      $display("FAIL flush_state: got v=%b rdy=%b want 0 1", ex_valid, if_ready); else n_pass++;
    ex_ready = 1'b1;
    tick();
    tick();
    n_total++; if (ex_valid !== 1'b0) $display("FAIL flush_empty: got ex_valid=%b want 0", ex_valid); else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    if_valid = 1'b1; if_inst = I_LW_X3;
    tick();
    if_inst = I_ADDI_X4_X3;
    tick();
    if_valid = 1'b0;
    mem_stall = 1'b1; // keeps the load pending in the scoreboard
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (ex_valid !== 1'b0 || ex_load !== 1'b0 || ex_wd !== 5'd0 || ex_alusel !== 5'd0 || ex_opr1 !== 32'd0)
      $display("FAIL mid_rst_outputs: got v=%b load=%b wd=%0d sel=%h o1=%h want 0", ex_valid, ex_load, ex_wd, ex_alusel, ex_opr1); else n_pass++;
    n_total++; if (if_ready !== 1'b1) $display("FAIL mid_rst_if_ready: got %b want 1", if_ready); else n_pass++;
    issue_one(32'h200, I_ADDI_X4_X3, 1'b0);
    n_total++; if (ex_valid !== 1'b1 || ex_opr1 !== 32'h1003 || ex_opr2 !== 32'd1)
      $display("FAIL mid_rst_addi: got v=%b o1=%h o2=%h want 1 1003 1", ex_valid, ex_opr1, ex_opr2); else n_pass++;
    mem_stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + 32'(i);
    rf_mem[0] = 32'hBAD0_0000; // x0 must never be taken from the register file
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_decode();
    test_full();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
